partition_sweep_engine: RTL
===========================

# partition_sweep_engine

Synthesizable exhaustive-sweep engine for approximate-logic partitions. It drives every input pattern 0 … 2^NUM_IN−1 into a partition under evaluation and streams each captured output vector. In the same pass it accumulates error metrics against an exact reference partition. It sits between the partition netlists (approximate and exact copies share `pi_o`) and the host-side collector, replacing per-partition enumeration benches with one parametrised, cycle-accurate block.

## Interface
Parameters:
- `NUM_IN`, 7: partition input count; sweep length is 2^NUM_IN (1 ≤ NUM_IN ≤ 20).
- `NUM_OUT`, 4: partition output count (1 ≤ NUM_OUT ≤ 32).
- `SETTLE`, 1: cycles each pattern is held before capture (≥ 1).

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE.
- `abort`  in  1  terminates a sweep in progress.
- `busy`  out  1  high in DRIVE/EMIT.
- `done`  out  1  high in DONE (sticky until next `start`).
- `pi_o`  out  NUM_IN  pattern driven to both partitions.
- `po_i`  in  NUM_OUT  approximate partition outputs.
- `ref_i`  in  NUM_OUT  exact partition outputs.
- `vec_valid`  out  1  captured vector available.
- `vec_ready`  in  1  consumer accepts vector.
- `vec_pi`  out  NUM_IN  pattern of captured vector.
- `vec_po`  out  NUM_OUT  captured `po_i`.
- `err_count`  out  NUM_IN+1  patterns where `po_i != ref_i`.
- `bit_flips`  out  NUM_IN+$clog2(NUM_OUT+1)  sum of Hamming distances.
- `wce`  out  NUM_OUT  worst-case |po−ref| (unsigned); present only with `SWEEP_WCE_EN`.

## Operation
- States: IDLE, DRIVE, EMIT, DONE. Reset → IDLE; all outputs 0.
- IDLE/DONE + `start`: clear `err_count`, `bit_flips`, `wce`, settle counter. Set `pi_o`=0. → DRIVE. `done` drops the same edge.
- DRIVE: hold `pi_o` for SETTLE cycles. On the edge ending the last DRIVE cycle:
  - latch `vec_pi`=`pi_o` and `vec_po`=`po_i`;
  - add popcount(`po_i`^`ref_i`) to `bit_flips`;
  - increment `err_count` if nonzero;
  - update `wce`;
  - → EMIT.
- EMIT: `vec_valid`=1, and `vec_pi`/`vec_po` stable until `vec_ready`. On handshake:
  - if `pi_o` is all-ones → DONE;
  - else `pi_o`+1 → DRIVE.
- `pi_o` never wraps; the final pattern is all-ones and exactly 2^NUM_IN vectors are emitted.
- `abort` in DRIVE/EMIT → IDLE next edge. `vec_valid` drops and metrics hold their partial values. `done` is not asserted. `abort` has priority over a simultaneous handshake. `abort` in IDLE/DONE is ignored.
- `start` while busy is ignored.
- `start` and `abort` together in IDLE/DONE: `start` wins.
- Metrics are readable at any time. They are final only while `done`=1.

## Timing
- `start` sampled at edge t: `pi_o`=0 visible after t. First capture at edge t+SETTLE. `vec_valid` is high from t+SETTLE.
- Each pattern costs SETTLE+1 cycles with `vec_ready` held high. A full sweep is 2^NUM_IN·(SETTLE+1) cycles from `start` to `done`.
- Metrics update on the capture edge, one cycle before that vector can handshake.
- `rst_n` low mid-sweep: immediate IDLE, all outputs 0. No vector is emitted after reset release until a new `start`.

## Configuration
- `SWEEP_WCE_EN` defined: `wce` port and a max-tracking register exist. The capture edge sets `wce`=max(`wce`, |`po_i`−`ref_i`|), compared as unsigned NUM_OUT-bit values.
- `SWEEP_WCE_EN` undefined: no `wce` port and no subtractor/comparator. All other behaviour is identical.

## Structure
- `sweep_pkg`: state enum `sweep_state_t`; width helper function for `bit_flips`; localparam for last pattern (all-ones).
- Sub-module `sweep_popcount` (parametrised NUM_OUT): combinational Hamming weight of `po_i`^`ref_i`.

## Test plan
NUM_IN=7, NUM_OUT=4, SETTLE=1 unless noted.
- `ref_i`=`po_i`=`pi_o[3:0]`, `vec_ready`=1 → 128 vectors with `vec_pi` 0…127 in order; `done` at cycle 256; `err_count`=0, `bit_flips`=0, `wce`=0.
- `ref_i`=`pi_o[3:0]`, `po_i`=`pi_o[3:0]`&4'b1110 → `err_count`=64, `bit_flips`=64, `wce`=1.
- Same as previous, but `vec_ready` random 30% high, SETTLE=3 → identical vector sequence and metrics; each vector stable until accepted.
- `abort` asserted while the `vec_pi`=40 vector is in EMIT → IDLE; `done`=0; `err_count`=20 (the odd patterns among 0…40); that vector is not handshaken.
- `start` pulsed mid-sweep → ignored. After `done`, `start` again → metrics cleared to 0 and the sweep restarts at `pi_o`=0.
- `rst_n` low at pattern 77 → all outputs 0 asynchronously. After release, the block stays IDLE with no `vec_valid`.

Source files
------------

// File: rtl/sweep_pkg.sv
// sweep_pkg: shared state encoding, width helper and last-pattern constant for the sweep engine
package sweep_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, EMIT, DONE} sweep_state_t;
    localparam int MAX_IN = 20;
    localparam logic [MAX_IN-1:0] LAST_PI = '1;
    function automatic int flips_width(input int num_in, input int num_out);
        return num_in + $clog2(num_out + 1);
    endfunction
endpackage

// File: rtl/sweep_popcount.sv
// sweep_popcount: combinational Hamming weight of the approximate/exact output difference
module sweep_popcount #(
    parameter int N = 4
) (
    input  logic [N-1:0]             a,
    input  logic [N-1:0]             b,
    output logic [$clog2(N+1)-1:0]   cnt
);
    localparam int PW = $clog2(N + 1);
    // count the set bits of a^b
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + PW'(a[i] ^ b[i]);
    end
endmodule

// File: rtl/partition_sweep_engine.sv
// partition_sweep_engine: exhaustive pattern sweep with vector streaming and error metrics; SWEEP_WCE_EN adds worst-case error tracking
module partition_sweep_engine
    import sweep_pkg::*;
#(
    parameter int NUM_IN  = 7,
    parameter int NUM_OUT = 4,
    parameter int SETTLE  = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   abort,
    output logic                                   busy,
    output logic                                   done,
    output logic [NUM_IN-1:0]                      pi_o,
    input  logic [NUM_OUT-1:0]                     po_i,
    input  logic [NUM_OUT-1:0]                     ref_i,
    output logic                                   vec_valid,
    input  logic                                   vec_ready,
    output logic [NUM_IN-1:0]                      vec_pi,
    output logic [NUM_OUT-1:0]                     vec_po,
    output logic [NUM_IN:0]                        err_count,
    output logic [flips_width(NUM_IN, NUM_OUT)-1:0] bit_flips
`ifdef SWEEP_WCE_EN
    ,
    output logic [NUM_OUT-1:0]                     wce
`endif
);
    localparam int FW = flips_width(NUM_IN, NUM_OUT);
    localparam int PW = $clog2(NUM_OUT + 1);
    localparam int CW = $clog2(SETTLE + 1);
    localparam int EW = NUM_IN + 1;

    sweep_state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pop;
    logic go, cap, hs, last;

    assign go        = (state == IDLE || state == DONE) && start;
    assign busy      = state == DRIVE || state == EMIT;
    assign done      = state == DONE;
    assign vec_valid = state == EMIT;
    assign last      = pi_o == LAST_PI[NUM_IN-1:0];
    assign cap       = state == DRIVE && !abort && cnt == CW'(SETTLE - 1);
    assign hs        = state == EMIT && !abort && vec_ready;

    sweep_popcount #(.N(NUM_OUT)) u_pop (.a(po_i), .b(ref_i), .cnt(pop));

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    // next state: start beats abort when idle, abort beats handshake when busy
    always_comb begin
        nxt = state;
        nxt = go ? DRIVE :
              busy && abort ? IDLE :
              cap ? EMIT :
              hs ? (last ? DONE : DRIVE) : state;
    end

    // pattern, settle counter, captured vector and error accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi_o      <= '0;
            cnt       <= '0;
            vec_pi    <= '0;
            vec_po    <= '0;
            err_count <= '0;
            bit_flips <= '0;
        end else if (go) begin
            pi_o      <= '0;
            cnt       <= '0;
            err_count <= '0;
            bit_flips <= '0;
        end else if (cap) begin
            cnt       <= '0;
            vec_pi    <= pi_o;
            vec_po    <= po_i;
            err_count <= err_count + EW'(|(po_i ^ ref_i));
            bit_flips <= bit_flips + FW'(pop);
        end else if (state == DRIVE && !abort) begin
            cnt <= cnt + CW'(1);
        end else if (hs && !last) begin
            pi_o <= pi_o + NUM_IN'(1);
        end
    end

`ifdef SWEEP_WCE_EN
    logic [NUM_OUT-1:0] diff;
    assign diff = po_i >= ref_i ? po_i - ref_i : ref_i - po_i;
    // running maximum of the unsigned absolute output error
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wce <= '0;
        else if (go) wce <= '0;
        else if (cap && diff > wce) wce <= diff;
`endif
endmodule
